// File: rtl/dv16_pkg.sv
// Shared definitions for the dv16 32/16 restoring divider.
package dv16_pkg;

  localparam int DV_AW   = 32;
  localparam int DV_BW   = 16;
  localparam int DV_ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } dv_state_t;

endpackage

// File: rtl/dv16_dvstep.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module dvstep
  import dv16_pkg::*;
(
  input  logic [DV_BW:0]   rem_in,
  input  logic [DV_BW-1:0] divisor,
  input  logic             bit_in,
  output logic [DV_BW:0]   rem_out,
  output logic             qbit
);

  logic [DV_BW+1:0] shifted;
  logic [DV_BW+1:0] diff;

  // The partial remainder is always below the divisor, so one extra bit absorbs the
  // shift and the top bit of the difference is the borrow.
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};
  assign qbit    = ~diff[DV_BW+1];
  assign rem_out = qbit ? diff[DV_BW:0] : shifted[DV_BW:0];

endmodule

// File: rtl/dv16.sv
// dv16: 32-bit by 16-bit signed/unsigned restoring divider, 16 iterations per result.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one quotient bit per cycle, cnt counts 0..15
// FIX   | apply signs / overflow check; early-exit results (b=0 or
//       | quotient too wide) also pass through here for one cycle so
//       | done lands one edge after acceptance
// DONE  | done pulse; a start here is accepted immediately
module dv16
  import dv16_pkg::*;
(
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic [DV_AW-1:0] a,
  input  logic [DV_BW-1:0] b,
  input  logic             sign,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [DV_BW-1:0] q,
  output logic [DV_BW-1:0] r,
  output logic             dz,
  output logic             ovf
);

  dv_state_t        state;
  logic [3:0]       cnt;
  logic [DV_BW-1:0] dvd;
  logic [DV_BW-1:0] qacc;
  logic [DV_BW-1:0] bmag;
  logic [DV_BW:0]   rem;
  logic [DV_BW:0]   rem_nxt;
  logic             qbit;
  logic             sgn_l;
  logic             neg_q;
  logic             neg_r;
  logic             early;
  logic             early_dz;

  logic [DV_AW-1:0] amag_c;
  logic [DV_BW-1:0] bmag_c;
  logic             b_zero;
  logic             too_big;
  logic [DV_BW-1:0] q_fix;
  logic [DV_BW-1:0] r_fix;
  logic             ovf_fix;

  assign amag_c  = (sign && a[DV_AW-1]) ? -a : a;
  assign bmag_c  = (sign && b[DV_BW-1]) ? -b : b;
  assign b_zero  = (b == '0);
  // Upper dividend half not below the divisor means the magnitude quotient needs 17+ bits.
  assign too_big = (amag_c[DV_AW-1:DV_BW] >= bmag_c);

  dvstep u_step (
    .rem_in  (rem),
    .divisor (bmag),
    .bit_in  (dvd[DV_BW-1]),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  // Sign application and signed-range overflow check on the magnitude result.
  always_comb begin
    q_fix   = qacc;
    r_fix   = rem[DV_BW-1:0];
    ovf_fix = 1'b0;
    if (sgn_l) begin
      if (neg_q) begin
        if (qacc > 16'h8000) ovf_fix = 1'b1;
        else                 q_fix   = -qacc;
      end else if (qacc > 16'h7FFF) begin
        ovf_fix = 1'b1;
      end
      if (neg_r) r_fix = -rem[DV_BW-1:0];
    end
    if (ovf_fix) begin
      q_fix = 16'hFFFF;
      r_fix = 16'h0000;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dvd      <= '0;
      qacc     <= '0;
      bmag     <= '0;
      rem      <= '0;
      sgn_l    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      early    <= 1'b0;
      early_dz <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sgn_l <= sign;
            neg_q <= sign & (a[DV_AW-1] ^ b[DV_BW-1]);
            neg_r <= sign & a[DV_AW-1];
            bmag  <= bmag_c;
            dvd   <= amag_c[DV_BW-1:0];
            cnt   <= 4'd0;
            if (b_zero) begin
              early    <= 1'b1;
              early_dz <= 1'b1;
              qacc     <= 16'hFFFF;
              rem      <= {1'b0, a[DV_BW-1:0]};
              state    <= FIX;
            end else if (too_big) begin
              early    <= 1'b1;
              early_dz <= 1'b0;
              qacc     <= 16'hFFFF;
              rem      <= '0;
              state    <= FIX;
            end else begin
              early    <= 1'b0;
              early_dz <= 1'b0;
              qacc     <= '0;
              rem      <= {1'b0, amag_c[DV_AW-1:DV_BW]};
              busy     <= 1'b1;
              state    <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem  <= rem_nxt;
          dvd  <= {dvd[DV_BW-2:0], 1'b0};
          qacc <= {qacc[DV_BW-2:0], qbit};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'(DV_ITER - 1)) state <= FIX;
        end
        FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
          if (early) begin
            q   <= qacc;
            r   <= rem[DV_BW-1:0];
            dz  <= early_dz;
            ovf <= ~early_dz;
          end else begin
            q   <= q_fix;
            r   <= r_fix;
            dz  <= 1'b0;
            ovf <= ovf_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
